step_pulse_gen: RTL and testbench

- Downstream stage of the step generator: converts the signed velocity it produces into discrete step events.
- Uses a prescaled phase accumulator (DDA) to time the steps and emits timed STEP/DIR pulses with DIR setup time.
- Keeps the 32-bit absolute step position; its low two bits feed the full-step waveform decoder that drives the coils.
- In external-control mode, uses synchronised external step/dir edges instead of the accumulator.

---
 rtl/stepper_pkg.sv | 21 ++
 rtl/step_rate_dda.sv | 56 +++++
 rtl/step_pulse_gen.sv | 157 +++++++++++++++
 tb/tb_step_pulse_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper pulse path: pulse FSM state encoding
// (kept identical to the step_gen encoding) and direction encoding.
package stepper_pkg;

    localparam logic [1:0] STEP_PULSE_IDLE      = 2'd0;
    localparam logic [1:0] STEP_PULSE_DIR_SETUP = 2'd1;
    localparam logic [1:0] STEP_PULSE_HIGH      = 2'd2;
    localparam logic [1:0] STEP_PULSE_LOW       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = STEP_PULSE_IDLE,
        ST_DIR_SETUP = STEP_PULSE_DIR_SETUP,
        ST_HIGH      = STEP_PULSE_HIGH,
        ST_LOW       = STEP_PULSE_LOW
    } pulse_state_e;

    // Direction bit as driven on dir_out: 1 means negative travel.
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/step_rate_dda.sv
// Prescaled phase accumulator: every TICK_DIV clocks it adds |velocity| and
// raises a one-cycle step request on each carry out of ACC_WIDTH bits.
// ACC_WIDTH is expected to be at least 16 so |velocity| (up to 2^15) fits.
module step_rate_dda
    import stepper_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int TICK_DIV  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        ext_mode,
    input  logic [15:0] velocity,
    output logic        req,
    output logic        req_dir
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]        presc;
    logic                 tick;
    logic [16:0]          vel_abs;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic                 acc_run;

    // |velocity| at 17 bits so that -32768 maps to +32768.
    always_comb begin
        vel_abs = velocity[15] ? (17'd0 - {1'b1, velocity}) : {1'b0, velocity};
        tick    = (presc == PW'(TICK_DIV - 1));
        acc_run = enable && !ext_mode && tick;
        sum     = {1'b0, acc} + (ACC_WIDTH + 1)'(vel_abs);
        req     = acc_run && sum[ACC_WIDTH];
        req_dir = velocity[15] ? DIR_NEG : DIR_POS;
    end

    // Free-running prescaler, wraps after TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    // Accumulator advances only on enabled ticks outside external mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (acc_run)
            acc <= sum[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Converts step requests (from the DDA or from external step/dir) into timed
// STEP/DIR pulses with DIR setup time, and tracks the absolute step position.
// Request handshake: a request is a single-cycle pulse with no ready; it lands
// in a one-deep pending slot, and if the slot is still full (not consumed
// this cycle) the request is dropped and the sticky overrun flag is raised.
module step_pulse_gen
    import stepper_pkg::*;
#(
    parameter int ACC_WIDTH        = 16,
    parameter int TICK_DIV         = 10,
    parameter int PULSE_CYCLES     = 4,
    parameter int DIR_SETUP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] velocity,
    input  logic        ext_mode,
    input  logic        ext_step_rise,
    input  logic        ext_dir,
    input  logic        pos_load,
    input  logic [31:0] pos_load_val,
    input  logic        overrun_clr,
    output logic        step_out,
    output logic        dir_out,
    output logic [31:0] step_pos,
    output logic [1:0]  coil_phase,
    output logic        busy,
    output logic        overrun,
    output logic [1:0]  state_dbg
);

    localparam int MAX_CNT = (PULSE_CYCLES > DIR_SETUP_CYCLES) ? PULSE_CYCLES : DIR_SETUP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    pulse_state_e state;
    logic [CNT_W-1:0] cnt;
    logic dda_req, dda_dir;
    logic req, req_dir;
    logic pend_valid, pend_dir;
    logic consume, drop, enter_high;

    step_rate_dda #(
        .ACC_WIDTH(ACC_WIDTH),
        .TICK_DIV (TICK_DIV)
    ) u_dda (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .ext_mode(ext_mode),
        .velocity(velocity),
        .req     (dda_req),
        .req_dir (dda_dir)
    );

    // Request source select and slot/FSM handover conditions.
    always_comb begin
        req        = ext_mode ? ext_step_rise : dda_req;
        req_dir    = ext_mode ? ext_dir : dda_dir;
        consume    = (state == ST_IDLE) && pend_valid;
        drop       = req && pend_valid && !consume;
        enter_high = (consume && (pend_dir == dir_out)) ||
                     ((state == ST_DIR_SETUP) && (cnt == '0));
    end

    // One-deep pending request slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_dir   <= DIR_POS;
        end else if (req && !drop) begin
            pend_valid <= 1'b1;
            pend_dir   <= req_dir;
        end else if (consume) begin
            pend_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
        else if (overrun_clr)
            overrun <= 1'b0;
    end

    // Pulse FSM with one shared down-counter and registered STEP/DIR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            step_out <= 1'b0;
            dir_out  <= DIR_POS;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        if (pend_dir != dir_out) begin
                            dir_out <= pend_dir;
                            cnt     <= CNT_W'(DIR_SETUP_CYCLES - 1);
                            state   <= ST_DIR_SETUP;
                        end else begin
                            step_out <= 1'b1;
                            cnt      <= CNT_W'(PULSE_CYCLES - 1);
                            state    <= ST_HIGH;
                        end
                    end
                end
                ST_DIR_SETUP: begin
                    if (cnt == '0) begin
                        step_out <= 1'b1;
                        cnt      <= CNT_W'(PULSE_CYCLES - 1);
                        state    <= ST_HIGH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt == '0) begin
                        step_out <= 1'b0;
                        cnt      <= CNT_W'(PULSE_CYCLES - 1);
                        state    <= ST_LOW;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt == '0)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Position counter: load wins over the step taken on entry to HIGH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step_pos <= '0;
        else if (pos_load)
            step_pos <= pos_load_val;
        else if (enter_high)
            step_pos <= (dir_out == DIR_NEG) ? step_pos - 32'd1 : step_pos + 32'd1;
    end

    // Status outputs derived from registered state.
    always_comb begin
        coil_phase = step_pos[1:0];
        busy       = (state != ST_IDLE) || pend_valid;
        state_dbg  = state;
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with default parameters
// (ACC_WIDTH=16, TICK_DIV=10, PULSE_CYCLES=4, DIR_SETUP_CYCLES=2).
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] velocity = '0;
  logic        ext_mode = 1'b0;
  logic        ext_step_rise = 1'b0;
  logic        ext_dir = 1'b0;
  logic        pos_load = 1'b0;
  logic [31:0] pos_load_val = '0;
  logic        overrun_clr = 1'b0;
  logic        step_out;
  logic        dir_out;
  logic [31:0] step_pos;
  logic [1:0]  coil_phase;
  logic        busy;
  logic        overrun;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;

  step_pulse_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .velocity     (velocity),
    .ext_mode     (ext_mode),
    .ext_step_rise(ext_step_rise),
    .ext_dir      (ext_dir),
    .pos_load     (pos_load),
    .pos_load_val (pos_load_val),
    .overrun_clr  (overrun_clr),
    .step_out     (step_out),
    .dir_out      (dir_out),
    .step_pos     (step_pos),
    .coil_phase   (coil_phase),
    .busy         (busy),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; velocity = '0; ext_mode = 1'b0; ext_step_rise = 1'b0;
    ext_dir = 1'b0; pos_load = 1'b0; pos_load_val = '0; overrun_clr = 1'b0;
    rst_n = 1'b0;
    step_cyc();
    step_cyc();
    rst_n = 1'b1;
  endtask

  // cycles until the next rising edge of step_out
  task automatic wait_rise(input int budget, output int waited, output bit ok);
    logic prev;
    prev = step_out;
    waited = 0;
    ok = 1'b0;
    while (waited < budget && !ok) begin
      step_cyc();
      waited++;
      if (!prev && step_out) ok = 1'b1;
      prev = step_out;
    end
  endtask

  // cycles until the next falling edge of step_out
  task automatic wait_fall(input int budget, output int waited, output bit ok);
    logic prev;
    prev = step_out;
    waited = 0;
    ok = 1'b0;
    while (waited < budget && !ok) begin
      step_cyc();
      waited++;
      if (prev && !step_out) ok = 1'b1;
      prev = step_out;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (step_out !== 1'b0 || dir_out !== 1'b0 || step_pos !== 32'd0 || busy !== 1'b0 ||
        overrun !== 1'b0 || coil_phase !== 2'd0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: step=%b dir=%b pos=%h busy=%b ovr=%b coil=%0d st=%0d, want all 0",
               step_out, dir_out, step_pos, busy, overrun, coil_phase, state_dbg);
    end
  endtask

  task automatic test_idle_hold();
    int rises;
    int waited;
    bit ok;
    logic prev;
    do_reset();
    rises = 0;
    prev = step_out;
    velocity = 16'd16384;
    enable = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step_cyc();
      if (!prev && step_out) rises++;
      prev = step_out;
    end
    velocity = 16'd0;
    enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step_cyc();
      if (!prev && step_out) rises++;
      prev = step_out;
    end
    total++;
    if (rises !== 0 || step_pos !== 32'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: rises=%0d pos=%h busy=%b, want 0 0 0", rises, step_pos, busy);
    end
    // prescaler is at 0 here; untouched acc needs 4 ticks, then 2 cycles latency
    velocity = 16'd16384;
    wait_rise(100, waited, ok);
    total++;
    if (!ok || waited !== 41) begin
      bad++;
      $display("FAIL first_step_latency: ok=%b waited=%0d, want 41", ok, waited);
    end
  endtask

  task automatic test_forward();
    int w;
    int g;
    bit ok1;
    bit ok2;
    do_reset();
    velocity = 16'd16384;
    enable = 1'b1;
    wait_rise(100, w, ok1);
    total++;
    if (!ok1 || step_pos !== 32'd1) begin
      bad++;
      $display("FAIL fwd_first: ok=%b pos=%h, want 1", ok1, step_pos);
    end
    for (int i = 2; i <= 10; i++) begin
      wait_fall(20, w, ok1);
      wait_rise(60, g, ok2);
      total++;
      if (!ok1 || !ok2 || w !== 4 || (w + g) !== 40) begin
        bad++;
        $display("FAIL fwd_period step%0d: high=%0d period=%0d, want 4 40", i, w, w + g);
      end
    end
    total++;
    if (step_pos !== 32'd10 || coil_phase !== 2'd2 || dir_out !== 1'b0) begin
      bad++;
      $display("FAIL fwd_pos: pos=%h coil=%0d dir=%b, want 10 2 0", step_pos, coil_phase, dir_out);
    end
  endtask

  task automatic test_reverse();
    int w;
    int n;
    bit ok;
    velocity = 16'hC000; // -16384
    n = 0;
    while (dir_out !== 1'b1 && n < 100) begin
      step_cyc();
      n++;
    end
    total++;
    if (dir_out !== 1'b1 || step_out !== 1'b0) begin
      bad++;
      $display("FAIL rev_dir: dir=%b step=%b, want 1 0", dir_out, step_out);
    end
    wait_rise(20, w, ok);
    total++;
    if (!ok || w !== 2) begin
      bad++;
      $display("FAIL rev_setup: ok=%b gap=%0d, want 2", ok, w);
    end
    total++;
    if (step_pos !== 32'd9) begin
      bad++;
      $display("FAIL rev_pos: pos=%h, want 9", step_pos);
    end
    velocity = 16'h8000; // -32768
    wait_rise(60, w, ok);
    total++;
    if (!ok || w !== 18) begin
      bad++;
      $display("FAIL max_neg_first: ok=%b gap=%0d, want 18", ok, w);
    end
    for (int i = 0; i < 2; i++) begin
      wait_rise(60, w, ok);
      total++;
      if (!ok || w !== 20) begin
        bad++;
        $display("FAIL max_neg_period: ok=%b gap=%0d, want 20", ok, w);
      end
    end
    total++;
    if (step_pos !== 32'd6 || coil_phase !== 2'd2 || dir_out !== 1'b1) begin
      bad++;
      $display("FAIL max_neg_pos: pos=%h coil=%0d dir=%b, want 6 2 1", step_pos, coil_phase, dir_out);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int w;
    bit ok;
    wait_rise(40, w, ok);
    step_cyc();
    total++;
    if (!ok || step_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_pulse_pre: ok=%b step=%b, want 1", ok, step_out);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (step_out !== 1'b0 || dir_out !== 1'b0 || step_pos !== 32'd0 || busy !== 1'b0 ||
        overrun !== 1'b0 || coil_phase !== 2'd0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL mid_pulse_reset: step=%b dir=%b pos=%h busy=%b ovr=%b st=%0d, want all 0",
               step_out, dir_out, step_pos, busy, overrun, state_dbg);
    end
    velocity = '0;
    enable = 1'b0;
    step_cyc();
    rst_n = 1'b1;
    step_cyc();
  endtask

  task automatic test_ext();
    do_reset();
    ext_mode = 1'b1;
    ext_dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ext_step_rise = 1'b1;
      step_cyc();
      ext_step_rise = 1'b0;
      step_cyc();
      if (k == 0) begin
        total++;
        if (step_out !== 1'b1) begin
          bad++;
          $display("FAIL ext_latency: step=%b, want 1", step_out);
        end
      end
      for (int i = 0; i < 18; i++) step_cyc();
    end
    total++;
    if (step_pos !== 32'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ext_three: pos=%h busy=%b, want 3 0", step_pos, busy);
    end
    for (int r = 0; r < 2; r++) begin
      ext_step_rise = 1'b1; step_cyc(); ext_step_rise = 1'b0; step_cyc();
      ext_step_rise = 1'b1; step_cyc(); ext_step_rise = 1'b0; step_cyc();
      ext_step_rise = 1'b1;
      overrun_clr = (r == 1);
      step_cyc();
      ext_step_rise = 1'b0;
      overrun_clr = 1'b0;
      total++;
      if (overrun !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL overrun_set round%0d: ovr=%b busy=%b, want 1 1", r, overrun, busy);
      end
      for (int i = 0; i < 30; i++) step_cyc();
      total++;
      if (step_pos !== 32'(5 + 2 * r) || busy !== 1'b0 || overrun !== 1'b1) begin
        bad++;
        $display("FAIL overrun_drain round%0d: pos=%h busy=%b ovr=%b, want %0d 0 1",
                 r, step_pos, busy, overrun, 5 + 2 * r);
      end
      overrun_clr = 1'b1;
      step_cyc();
      overrun_clr = 1'b0;
      total++;
      if (overrun !== 1'b0) begin
        bad++;
        $display("FAIL overrun_clr round%0d: ovr=%b, want 0", r, overrun);
      end
    end
  endtask

  task automatic test_pos_load();
    pos_load = 1'b1;
    pos_load_val = 32'h7FFF_FFFF;
    step_cyc();
    pos_load = 1'b0;
    total++;
    if (step_pos !== 32'h7FFF_FFFF) begin
      bad++;
      $display("FAIL pos_load: pos=%h, want 7fffffff", step_pos);
    end
    ext_dir = 1'b0;
    ext_step_rise = 1'b1; step_cyc(); ext_step_rise = 1'b0;
    for (int i = 0; i < 12; i++) step_cyc();
    total++;
    if (step_pos !== 32'h8000_0000) begin
      bad++;
      $display("FAIL pos_wrap_up: pos=%h, want 80000000", step_pos);
    end
    ext_step_rise = 1'b1; step_cyc(); ext_step_rise = 1'b0;
    pos_load = 1'b1;
    pos_load_val = 32'h1234_5678;
    step_cyc();
    pos_load = 1'b0;
    total++;
    if (step_out !== 1'b1 || step_pos !== 32'h1234_5678) begin
      bad++;
      $display("FAIL load_vs_step: step=%b pos=%h, want 1 12345678", step_out, step_pos);
    end
    for (int i = 0; i < 12; i++) step_cyc();
    total++;
    if (step_pos !== 32'h1234_5678 || step_out !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL load_vs_step_after: pos=%h step=%b busy=%b, want 12345678 0 0",
               step_pos, step_out, busy);
    end
    pos_load = 1'b1;
    pos_load_val = 32'd0;
    step_cyc();
    pos_load = 1'b0;
    ext_dir = 1'b1;
    ext_step_rise = 1'b1; step_cyc(); ext_step_rise = 1'b0;
    for (int i = 0; i < 15; i++) step_cyc();
    total++;
    if (step_pos !== 32'hFFFF_FFFF || coil_phase !== 2'd3 || dir_out !== 1'b1) begin
      bad++;
      $display("FAIL pos_wrap_down: pos=%h coil=%0d dir=%b, want ffffffff 3 1",
               step_pos, coil_phase, dir_out);
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_forward();
    test_reverse();
    test_reset_mid_pulse();
    test_ext();
    test_pos_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
